// File: rtl/demux_datapath.sv
// Registered 1-to-4 demultiplexer with saturating per-lane route counters.
// Latency: 1 cycle from d/s/en sampling to y/y_valid; counters update on the same edge.
// No backpressure: every edge with en=1 routes one word; downstream must accept it.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset; clears y, y_valid and all counters
//   en       route enable; when low, every lane and y_valid are driven to 0
//   d        data word to route
//   s        lane select 0..3
//   y        four lanes, lane i = y[i*DATA_W +: DATA_W]; unselected lanes are 0
//   y_valid  one-hot marker of the lane written on the previous edge; 0 if none
//   cnt_clr  synchronous clear of all counters; wins over a simultaneous increment
//   cnt      four counters, lane i = cnt[i*CNT_W +: CNT_W]; saturate at all-ones
module demux_datapath #(
   parameter int DATA_W = 1,
   parameter int CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [DATA_W-1:0]   d,
   input  logic [1:0]          s,
   output logic [4*DATA_W-1:0] y,
   output logic [3:0]          y_valid,
   input  logic                cnt_clr,
   output logic [4*CNT_W-1:0]  cnt
);

   logic [4*DATA_W-1:0] r_y;
   logic [3:0]          r_vld;
   logic [CNT_W-1:0]    r_cnt [4];

   // One-hot decode of the select; only meaningful when en is high.
   logic [3:0]          w_sel;
   logic [3:0]          w_route;

   assign w_sel   = 4'b0001 << s;
   assign w_route = en ? w_sel : 4'b0000;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y   <= '0;
         r_vld <= '0;
         for (int i = 0; i < 4; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         // Every lane is rewritten each edge so a lane never keeps stale data
         // after the select moves away from it.
         r_vld <= w_route;
         for (int i = 0; i < 4; i++) begin
            r_y[i*DATA_W +: DATA_W] <= w_route[i] ? d : '0;
         end

         for (int i = 0; i < 4; i++) begin
            if (cnt_clr) begin
               r_cnt[i] <= '0;
            end else if (w_route[i] && !(&r_cnt[i])) begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign y       = r_y;
   assign y_valid = r_vld;

   for (genvar g = 0; g < 4; g++) begin : g_cnt_out
      assign cnt[g*CNT_W +: CNT_W] = r_cnt[g];
   end

endmodule

// File: tb/tb_demux_datapath.sv
// Directed and random stimulus for demux_datapath against a lane-level reference model.
// Inputs are driven 1ns after the rising edge; outputs are checked 1ns after the edge.
// The model keeps each lane value and counter as plain integers.
module tb_demux_datapath;

   localparam int DW  = 1;
   localparam int CW  = 8;
   localparam int MAX = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic [DW-1:0]   d;
   logic [1:0]      s;
   logic [4*DW-1:0] y;
   logic [3:0]      y_valid;
   logic            cnt_clr;
   logic [4*CW-1:0] cnt;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state.
   int m_y   [4];
   int m_vld;          // lane index written last cycle, -1 if none
   int m_cnt [4];

   demux_datapath #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .d       (d),
      .s       (s),
      .y       (y),
      .y_valid (y_valid),
      .cnt_clr (cnt_clr),
      .cnt     (cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_y[i]   = 0;
         m_cnt[i] = 0;
      end
      m_vld = -1;
   endtask

   // Apply the sampled inputs of one rising edge to the model.
   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < 4; i++) m_y[i] = 0;
         m_vld = -1;
         if (en) begin
            m_y[int'(s)] = int'(d);
            m_vld        = int'(s);
         end
         for (int i = 0; i < 4; i++) begin
            if (cnt_clr)
               m_cnt[i] = 0;
            else if (en && int'(s) == i && m_cnt[i] < MAX)
               m_cnt[i] = m_cnt[i] + 1;
         end
      end
   endtask

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic check_all(input string tag);
      logic [4*DW-1:0] ey;
      logic [3:0]      ev;
      logic [4*CW-1:0] ec;
      ey = '0;
      ec = '0;
      for (int i = 0; i < 4; i++) begin
         ey[i*DW +: DW] = DW'(m_y[i]);
         ec[i*CW +: CW] = CW'(m_cnt[i]);
      end
      ev = (m_vld < 0) ? 4'b0000 : 4'(1 << m_vld);
      check_val({tag, ".y"},       64'(y),       64'(ey));
      check_val({tag, ".y_valid"}, 64'(y_valid), 64'(ev));
      check_val({tag, ".cnt"},     64'(cnt),     64'(ec));
   endtask

   // Drive one set of inputs, let one rising edge consume them, then check.
   task automatic step(input logic i_en, input logic [DW-1:0] i_d,
                       input logic [1:0] i_s, input logic i_clr, input string tag);
      en      = i_en;
      d       = i_d;
      s       = i_s;
      cnt_clr = i_clr;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      rst     = 1'b1;
      en      = 1'b0;
      d       = '0;
      s       = 2'd0;
      cnt_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      // Sweep all lanes with d=1.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 2'(i), 1'b0, "sweep");
      end
      check_val("sweep_y_last", 64'(y), 64'h8);
      check_val("sweep_cnt",    64'(cnt), 64'h01010101);

      // Disabled cycle: nothing written, counters hold.
      step(1'b0, 1'b1, 2'd1, 1'b0, "en0");
      check_val("en0_cnt", 64'(cnt), 64'h01010101);

      // Zero data still routes and counts.
      step(1'b1, 1'b0, 2'd3, 1'b0, "d0");
      check_val("d0_vld", 64'(y_valid), 64'h8);
      check_val("d0_cnt3", 64'(cnt[3*CW +: CW]), 64'd2);

      // Saturation on lane 0.
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b1, 2'd0, 1'b0, "sat");
      end
      check_val("sat_cnt0", 64'(cnt[CW-1:0]), 64'(MAX));

      // Clear wins over a simultaneous increment.
      step(1'b1, 1'b1, 2'd0, 1'b1, "clr");
      check_val("clr_cnt0", 64'(cnt[CW-1:0]), 64'd0);

      // Asynchronous reset in the middle of a cycle with y=0100.
      step(1'b1, 1'b1, 2'd2, 1'b0, "pre_rst");
      check_val("pre_rst_y", 64'(y), 64'h4);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check_all("async_rst");
      step(1'b1, 1'b1, 2'd1, 1'b0, "held_rst");
      rst = 1'b0;
      step(1'b1, 1'b1, 2'd1, 1'b0, "post_rst");
      check_val("post_rst_y", 64'(y), 64'h2);

      // Random traffic.
      for (int i = 0; i < 1000; i++) begin
         step(1'($urandom_range(0, 3) != 0), DW'($urandom), 2'($urandom),
              1'($urandom_range(0, 49) == 0), "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
